// File: rtl/autobaud_ctrl_if.sv
// Signal bundle between the auto-baud controller and its host/baud generator.
// div_we_o qualifies div_o for exactly one cycle and done_o marks a successful measurement; neither strobe has backpressure.
interface autobaud_ctrl_if #(
  parameter int DIV_W = 16
);
  logic             rx_i;
  logic             start_i;
  logic             abort_i;
  logic [DIV_W-1:0] sw_div_i;
  logic             sw_div_we_i;
  logic [DIV_W-1:0] div_o;
  logic             div_we_o;
  logic             baud_en_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [2:0]       state_o;

  modport slave (
    input  rx_i, start_i, abort_i, sw_div_i, sw_div_we_i,
    output div_o, div_we_o, baud_en_o, busy_o, done_o, err_o, state_o
  );

  modport master (
    output rx_i, start_i, abort_i, sw_div_i, sw_div_we_i,
    input  div_o, div_we_o, baud_en_o, busy_o, done_o, err_o, state_o
  );
endinterface

// File: rtl/autobaud_ctrl.sv
// Baud divider controller: software divider pass-through, or auto-baud measurement
// of a 0x55 sync character over 8 bit times (1st to 5th falling edge).
module autobaud_ctrl #(
  parameter int OSR   = 16,
  parameter int DIV_W = 16,
  parameter int CNT_W = 24
) (
  input  logic           clk_i,
  input  logic           reset_i,
  autobaud_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_IDLE  = 3'd1,
    S_WAIT_START = 3'd2,
    S_MEASURE    = 3'd3,
    S_CALC       = 3'd4,
    S_WRITE      = 3'd5
  } state_e;

  localparam int SH = 3 + $clog2(OSR);
  localparam int CW = (CNT_W + 1 > DIV_W + 1) ? CNT_W + 1 : DIV_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0]    ROUND   = CW'(4 * OSR);

  state_e           state_q, state_d;
  logic             rx_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       edges_q, edges_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             div_valid_q, div_valid_d;
  logic             sw_we_q, sw_we_d;
  logic             err_q, err_d;

  logic             fall;
  logic [CW-1:0]    sum;
  logic [CW-1:0]    quo;
  logic             quo_bad;
  logic             div_we;

  assign fall    = rx_q & ~bus.rx_i;
  // Widened so the rounding add cannot overflow and the range test sees all quotient bits.
  assign sum     = {{(CW-CNT_W){1'b0}}, cnt_q} + ROUND;
  assign quo     = sum >> SH;
  assign quo_bad = (quo == '0) | (|(quo >> DIV_W));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      rx_q        <= 1'b1;
      cnt_q       <= '0;
      edges_q     <= '0;
      div_q       <= '0;
      div_valid_q <= 1'b0;
      sw_we_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_q        <= bus.rx_i;
      cnt_q       <= cnt_d;
      edges_q     <= edges_d;
      div_q       <= div_d;
      div_valid_q <= div_valid_d;
      sw_we_q     <= sw_we_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edges_d     = edges_q;
    div_d       = div_q;
    div_valid_d = div_valid_q;
    sw_we_d     = 1'b0;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        // A write strobe already on the bus blocks a back-to-back write so strobes never stretch.
        if (bus.sw_div_we_i && !sw_we_q) begin
          div_d       = bus.sw_div_i;
          sw_we_d     = 1'b1;
          div_valid_d = 1'b1;
          err_d       = 1'b0;
        end else if (bus.start_i) begin
          err_d   = 1'b0;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (bus.rx_i) state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (fall) begin
          cnt_d   = '0;
          edges_d = '0;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (fall) begin
            if (edges_q == 2'd3) state_d = S_CALC;
            else                 edges_d = edges_q + 2'd1;
          end
        end
      end
      S_CALC: begin
        if (quo_bad) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_d   = quo[DIV_W-1:0];
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        div_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort_i && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      div_d       = div_q;
      div_valid_d = div_valid_q;
      err_d       = err_q;
    end
  end

  assign div_we        = sw_we_q | (state_q == S_WRITE);
  assign bus.div_o     = div_q;
  assign bus.div_we_o  = div_we;
  assign bus.done_o    = (state_q == S_WRITE);
  assign bus.busy_o    = (state_q != S_IDLE);
  assign bus.baud_en_o = (state_q == S_IDLE) & div_valid_q & ~div_we;
  assign bus.err_o     = err_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_autobaud_ctrl.sv
// Directed bench for autobaud_ctrl: scoreboard of expected divider writes plus
// point checks of status outputs around each scenario.
module tb_autobaud_ctrl;

  localparam int DIV_W = 16;
  localparam int W     = DIV_W + 1;

  logic   clk;
  logic   rst;
  longint cyc;
  longint fall5_cyc;
  int     checks;
  int     failures;
  logic   prev_we;

  logic [W-1:0] exp_q[$];

  autobaud_ctrl_if #(.DIV_W(DIV_W)) bus();

  autobaud_ctrl #(.OSR(16), .DIV_W(DIV_W), .CNT_W(12)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  initial prev_we = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      if (bus.div_we_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: div_o=%0d done_o=%0d, none expected", bus.div_o, bus.done_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_div", bus.div_o, e[DIV_W-1:0]);
          check("sb_done", bus.done_o, e[DIV_W]);
          if (e[DIV_W]) check("write_latency", cyc - fall5_cyc, 2);
        end
        if (prev_we) check("we_two_cycles", 1, 0);
      end else if (bus.done_o) begin
        check("done_without_we", 1, 0);
      end
      prev_we = bus.div_we_o;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic pulse_abort();
    tick();
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
  endtask

  task automatic sw_write(input int v, input bit expect_write);
    if (expect_write) exp_q.push_back({1'b0, DIV_W'(v)});
    tick();
    bus.sw_div_i    = DIV_W'(v);
    bus.sw_div_we_i = 1'b1;
    tick();
    bus.sw_div_we_i = 1'b0;
  endtask

  // 0x55 LSB-first framed: start, 1,0,1,0,1,0,1,0, stop
  task automatic send_sync(input int bt);
    logic [9:0] frame;
    frame = 10'b1010101010;
    bus.rx_i = 1'b1;
    repeat (3) tick();
    for (int p = 0; p < 10; p++) begin
      bus.rx_i = frame[p];
      if (p == 8) fall5_cyc = cyc;
      repeat (bt) tick();
    end
    bus.rx_i = 1'b1;
  endtask

  task automatic wait_idle(input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!bus.busy_o) break;
    end
    check(name, bus.busy_o, 0);
  endtask

  task automatic auto_case(input int bt, input int exp_div);
    pulse_start();
    exp_q.push_back({1'b1, DIV_W'(exp_div)});
    send_sync(bt);
    wait_idle(50, "auto_idle");
    check("auto_div", bus.div_o, exp_div);
    check("auto_err", bus.err_o, 0);
    check("auto_baud_en", bus.baud_en_o, 1);
  endtask

  initial begin
    longint c0;
    checks          = 0;
    failures        = 0;
    fall5_cyc       = 0;
    rst             = 1'b1;
    bus.rx_i        = 1'b1;
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.sw_div_i    = '0;
    bus.sw_div_we_i = 1'b0;

    // reset and idle
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("rst_div", bus.div_o, 0);
    check("rst_we", bus.div_we_o, 0);
    check("rst_baud_en", bus.baud_en_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_err", bus.err_o, 0);

    // software write
    sw_write(27, 1'b1);
    @(negedge clk);
    check("sw_we_cycle_baud_en", bus.baud_en_o, 0);
    @(negedge clk);
    check("sw_baud_en", bus.baud_en_o, 1);
    check("sw_div_held", bus.div_o, 27);

    // auto-baud and rounding
    auto_case(160, 10);
    auto_case(170, 11);
    auto_case(167, 10);

    // too fast: quotient rounds to zero
    pulse_start();
    send_sync(4);
    wait_idle(50, "fast_idle");
    check("fast_err", bus.err_o, 1);
    check("fast_div_kept", bus.div_o, 10);

    // counter saturation
    pulse_start();
    @(negedge clk);
    check("start_clears_err", bus.err_o, 0);
    repeat (2) tick();
    bus.rx_i = 1'b0;
    c0 = cyc;
    wait_idle(5000, "sat_idle");
    check("sat_err", bus.err_o, 1);
    check("sat_time", ((cyc - c0) >= 4095 && (cyc - c0) <= 4100) ? 1 : 0, 1);
    bus.rx_i = 1'b1;
    pulse_start();
    @(negedge clk);
    check("restart_clears_err", bus.err_o, 0);
    check("restart_busy", bus.busy_o, 1);
    pulse_abort();
    wait_idle(5, "restart_abort_idle");

    // abort mid-measure
    pulse_start();
    repeat (3) tick();
    bus.rx_i = 1'b0;
    repeat (20) tick();
    bus.rx_i = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("in_measure", bus.state_o, 3);
    pulse_abort();
    @(negedge clk);
    check("abort_busy", bus.busy_o, 0);
    check("abort_div", bus.div_o, 10);
    check("abort_baud_en", bus.baud_en_o, 1);
    check("abort_err", bus.err_o, 0);

    // software write while busy is dropped
    pulse_start();
    sw_write(99, 1'b0);
    @(negedge clk);
    check("busy_sw_div", bus.div_o, 10);
    check("busy_sw_busy", bus.busy_o, 1);
    pulse_abort();
    wait_idle(5, "busy_sw_idle");

    // start and sw write in the same idle cycle: write wins
    exp_q.push_back({1'b0, DIV_W'(33)});
    tick();
    bus.sw_div_i    = DIV_W'(33);
    bus.sw_div_we_i = 1'b1;
    bus.start_i     = 1'b1;
    tick();
    bus.sw_div_we_i = 1'b0;
    bus.start_i     = 1'b0;
    @(negedge clk);
    check("both_busy", bus.busy_o, 0);
    check("both_div", bus.div_o, 33);

    // reset mid-operation
    pulse_start();
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_div", bus.div_o, 0);
    check("midrst_baud_en", bus.baud_en_o, 0);
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("midrst_baud_en_after", bus.baud_en_o, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
